hazard_control_unit: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RISC-V core, the producer-side counterpart of the forwarding unit. The forwarding unit resolves data hazards by bypassing results. This block handles everything bypassing cannot fix:
- load-use stalls,
- taken-branch/jump flushes,
- multi-cycle data-memory waits.

It drives the PC and pipeline-register write/flush controls and keeps saturating stall/flush statistics plus a memory-timeout flag.

---
 rtl/hazard_control_unit.sv | 156 +++++++++++++++
 tb/tb_hazard_control_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes, data-memory
// freezes, plus saturating stall/flush statistics and a sticky memory-timeout flag.
module hazard_control_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode_ID,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic [4:0]       rd_EX,
  input  logic             memread_EX,
  input  logic             memread_MEM,
  input  logic             memwrite_MEM,
  input  logic             dmem_ready,
  input  logic             branch_taken_EX,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IDEX_write,
  output logic             EXMEM_write,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             IDEX_bubble,
  output logic             MEMWB_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // TIMEOUT is expected to be at least 1.
  localparam int unsigned WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic {ST_RUN, ST_WAIT} state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;

  logic rs1_used, rs2_used, load_use, freeze;

  // Operand usage decode, same opcode sets as the forwarding unit.
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode_ID)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      7'b0000011, 7'b0010011, 7'b1100111: rs1_used = 1'b1;
      default: ;
    endcase
  end

  assign load_use = memread_EX && (rd_EX != 5'd0) &&
                    ((rs1_used && (rs1_ID == rd_EX)) || (rs2_used && (rs2_ID == rd_EX)));
  assign freeze   = (memread_MEM || memwrite_MEM) && !dmem_ready;

  // Same-cycle control decode in priority order: freeze, branch, load-use, run.
  always_comb begin
    PC_write     = 1'b1;
    IFID_write   = 1'b1;
    IDEX_write   = 1'b1;
    EXMEM_write  = 1'b1;
    IFID_flush   = 1'b0;
    IDEX_flush   = 1'b0;
    IDEX_bubble  = 1'b0;
    MEMWB_bubble = 1'b0;
    if (freeze) begin
      PC_write     = 1'b0;
      IFID_write   = 1'b0;
      IDEX_write   = 1'b0;
      EXMEM_write  = 1'b0;
      MEMWB_bubble = 1'b1;
    end else if (branch_taken_EX) begin
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end else if (load_use) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_bubble = 1'b1;
    end
    if (!rst_n) begin
      PC_write     = 1'b0;
      IFID_write   = 1'b0;
      IDEX_write   = 1'b0;
      EXMEM_write  = 1'b0;
      IFID_flush   = 1'b0;
      IDEX_flush   = 1'b0;
      IDEX_bubble  = 1'b0;
      MEMWB_bubble = 1'b0;
    end
  end

  // Next-state: wait tracking, timeout flag and statistics.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;

    case (state_q)
      ST_RUN: begin
        // wait_cnt is zero in RUN, so the first frozen edge lands on 1.
        wait_cnt_d = freeze ? WAIT_W'(1) : '0;
        if (freeze) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (freeze) begin
          if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
          wait_cnt_d = '0;
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (freeze && (wait_cnt_d == WAIT_MAX)) mem_timeout_d = 1'b1;

    if ((freeze || (load_use && !branch_taken_EX)) && (stall_count_q != CNT_MAX))
      stall_count_d = stall_count_q + CNT_W'(1);
    if (branch_taken_EX && !freeze && (flush_count_q != CNT_MAX))
      flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: driver pushes model expectations,
// monitor pops and compares on the falling edge.
module tb_hazard_control_unit;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       opcode_ID = '0;
  logic [4:0]       rs1_ID = '0, rs2_ID = '0, rd_EX = '0;
  logic             memread_EX = 1'b0, memread_MEM = 1'b0, memwrite_MEM = 1'b0;
  logic             dmem_ready = 1'b1, branch_taken_EX = 1'b0;
  logic             PC_write, IFID_write, IDEX_write, EXMEM_write;
  logic             IFID_flush, IDEX_flush, IDEX_bubble, MEMWB_bubble, mem_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;

  hazard_control_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_ID(opcode_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rd_EX(rd_EX), .memread_EX(memread_EX), .memread_MEM(memread_MEM),
    .memwrite_MEM(memwrite_MEM), .dmem_ready(dmem_ready), .branch_taken_EX(branch_taken_EX),
    .PC_write(PC_write), .IFID_write(IFID_write), .IDEX_write(IDEX_write),
    .EXMEM_write(EXMEM_write), .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .IDEX_bubble(IDEX_bubble), .MEMWB_bubble(MEMWB_bubble), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       ctrl;  // {PC,IFID,IDEX,EXMEM writes, IFID/IDEX flush, IDEX/MEMWB bubble}
    logic             tmo;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model state: consecutive frozen edges and saturating counters.
  int m_consec = 0, m_stall = 0, m_flush = 0;
  bit m_tmo = 1'b0;

  function automatic bit uses_rs1(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011, 7'b0000011, 7'b0010011, 7'b1100111};
  endfunction

  function automatic bit uses_rs2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  task automatic push_exp(input logic [7:0] ctrl);
    exp_t e;
    e.ctrl  = ctrl;
    e.tmo   = m_tmo;
    e.stall = CNT_W'(m_stall);
    e.flush = CNT_W'(m_flush);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic mre, input logic mrm,
                      input logic mwm, input logic rdy, input logic br);
    bit lu, frz;
    logic [7:0] ctrl;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    opcode_ID = op; rs1_ID = r1; rs2_ID = r2; rd_EX = rd;
    memread_EX = mre; memread_MEM = mrm; memwrite_MEM = mwm;
    dmem_ready = rdy; branch_taken_EX = br;
    lu  = mre && rd != 0 && ((uses_rs1(op) && r1 == rd) || (uses_rs2(op) && r2 == rd));
    frz = (mrm || mwm) && !rdy;
    if (frz)     ctrl = 8'b0000_0001;
    else if (br) ctrl = 8'b1111_1100;
    else if (lu) ctrl = 8'b0011_0010;
    else         ctrl = 8'b1111_0000;
    push_exp(ctrl);
    m_consec = frz ? m_consec + 1 : 0;
    if (m_consec >= int'(TIMEOUT)) m_tmo = 1'b1;
    if ((frz || (lu && !br)) && m_stall < CNT_MAX) m_stall++;
    if (br && !frz && m_flush < CNT_MAX) m_flush++;
  endtask

  // Asserts reset mid-cycle with optionally frozen inputs; outputs must drop at once.
  task automatic rst_step(input logic frz_in);
    @(posedge clk);
    #1;
    memread_MEM = frz_in; dmem_ready = !frz_in; branch_taken_EX = frz_in;
    rst_n = 1'b0;
    m_consec = 0; m_stall = 0; m_flush = 0; m_tmo = 1'b0;
    push_exp(8'b0);
  endtask

  task automatic idle();
    step(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic frz_step(input logic br);
    step(7'b0110011, 5'd5, 5'd6, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, br);
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {PC_write, IFID_write, IDEX_write, EXMEM_write,
               IFID_flush, IDEX_flush, IDEX_bubble, MEMWB_bubble};
        checks++;
        if (got === e.ctrl) passes++;
        else $display("FAIL ctrl t=%0t got %b want %b", $time, got, e.ctrl);
        checks++;
        if (mem_timeout === e.tmo) passes++;
        else $display("FAIL mem_timeout t=%0t got %b want %b", $time, mem_timeout, e.tmo);
        checks++;
        if (stall_count === e.stall) passes++;
        else $display("FAIL stall_count t=%0t got %0d want %0d", $time, stall_count, e.stall);
        checks++;
        if (flush_count === e.flush) passes++;
        else $display("FAIL flush_count t=%0t got %0d want %0d", $time, flush_count, e.flush);
      end
    end
  end

  initial begin
    logic [6:0] ops [8];
    ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0000011,
            7'b0010011, 7'b1100111, 7'b0110111, 7'b1101111};

    rst_step(1'b0);
    rst_step(1'b0);
    idle();
    // Load-use stall, lasting one cycle.
    step(7'b0110011, 5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    // Load into x0, and I-type whose rs2 field matches: no stall.
    step(7'b0110011, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(7'b0010011, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // Branch overrides load-use.
    step(7'b0110011, 5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    // Memory wait with pending branch, released after 3 cycles.
    rst_step(1'b0);
    for (int i = 0; i < 3; i++) frz_step(1'b1);
    step(7'b0110011, 5'd5, 5'd6, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle();
    // Timeout after TIMEOUT frozen edges; sticky until reset.
    rst_step(1'b0);
    for (int i = 0; i < 6; i++) frz_step(1'b0);
    idle();
    idle();
    // Reset in the middle of a wait.
    rst_step(1'b0);
    frz_step(1'b0);
    frz_step(1'b0);
    rst_step(1'b1);
    idle();
    idle();
    // Stall counter saturation.
    for (int i = 0; i < (1 << CNT_W) + 5; i++) frz_step(1'b0);
    idle();
    rst_step(1'b0);
    // Randomized traffic over small register range to provoke matches.
    for (int i = 0; i < 400; i++) begin
      step(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      if ($urandom_range(0, 99) == 0) rst_step(1'($urandom_range(0, 1)));
    end
    idle();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain pending %0d want 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
